// File: rtl/fir_sys_pkg.sv
// Shared constants for the FIR job system: memory geometry, buffer map and
// the sequencer state encoding.
package fir_sys_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 512;
  localparam int MAX_LEN  = 512;
  localparam int TIMEOUT  = 4096;

  // Sequencer states, 3-bit encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_KICK  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/sample_ram.sv
// Dual-port sample memory: port A is an asynchronous read port, port B is a
// synchronous write port. Contents are never cleared by reset.
module sample_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              we_b
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign data_a = mem[addr_a];

  // Port B write on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
  end

endmodule

// File: rtl/fir_job_sequencer.sv
// Job-level host for the pipelined FIR. Takes a job length, loads samples
// into the shared RAM, kicks the FIR, waits for its done edge (with a
// timeout) and streams the results out through a one-entry output register.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. cmd_ready is high only in IDLE, in_ready only in LOAD. The
// result stream holds out_data/out_last stable while out_valid && !out_ready.
module fir_job_sequencer
  import fir_sys_pkg::*;
#(
  parameter int ADDR_W   = fir_sys_pkg::ADDR_W,
  parameter int DATA_W   = fir_sys_pkg::DATA_W,
  parameter int IN_BASE  = fir_sys_pkg::IN_BASE,
  parameter int OUT_BASE = fir_sys_pkg::OUT_BASE,
  parameter int MAX_LEN  = fir_sys_pkg::MAX_LEN,
  parameter int TIMEOUT  = fir_sys_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic              fir_start,
  output logic [ADDR_W-1:0] fir_input_addr,
  output logic [ADDR_W-1:0] fir_output_addr,
  output logic [ADDR_W-1:0] fir_sample_count,
  input  logic              fir_done,
  input  logic [ADDR_W-1:0] fir_mem_addr_a,
  output logic [DATA_W-1:0] fir_mem_data_out_a,
  input  logic [ADDR_W-1:0] fir_mem_addr_b,
  input  logic [DATA_W-1:0] fir_mem_data_in_b,
  input  logic              fir_mem_we_b
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W:0]   MAX_LEN_X = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  // The input buffer must not overlap the output buffer, and MAX_LEN must
  // be representable in a length field.
  if (IN_BASE + MAX_LEN > OUT_BASE) begin : g_bad_map
    $error("fir_job_sequencer: input buffer overlaps output buffer");
  end
  if (MAX_LEN >= (1 << ADDR_W)) begin : g_bad_len
    $error("fir_job_sequencer: MAX_LEN does not fit in ADDR_W bits");
  end

  logic [2:0]        state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     timer;
  logic              done_q;

  logic              cmd_bad;
  logic              in_fire;
  logic              rise;
  logic              timeout_hit;
  logic              drain_end;
  logic              drain_load;

  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic              ram_we_b;

  assign cmd_bad     = (cmd_len == '0) || ({1'b0, cmd_len} > MAX_LEN_X);
  assign in_fire     = in_valid && in_ready;
  // A done level still high from the previous job is not a completion;
  // only a fresh 0->1 transition is.
  assign rise        = fir_done && !done_q;
  assign timeout_hit = (state == ST_RUN) && !rise && (timer == TW'(TIMEOUT - 1));
  assign drain_end   = out_valid && out_ready && out_last;
  assign drain_load  = !out_valid || out_ready;

  // Status and pulse outputs are suppressed while reset is held so an abort
  // never leaks a start or an err.
  assign cmd_ready        = !rst && (state == ST_IDLE);
  assign in_ready         = !rst && (state == ST_LOAD);
  assign busy             = (state != ST_IDLE);
  assign fir_start        = !rst && (state == ST_KICK);
  assign err              = !rst && (((state == ST_IDLE) && cmd_valid && cmd_bad) || timeout_hit);
  assign fir_input_addr   = ADDR_W'(IN_BASE);
  assign fir_output_addr  = ADDR_W'(OUT_BASE);
  assign fir_sample_count = len;

  // RAM port ownership: sequencer writes in LOAD, reads in DRAIN; the FIR
  // owns both ports in RUN. Writes are blocked in every other state.
  always_comb begin
    ram_addr_a = fir_mem_addr_a;
    ram_addr_b = fir_mem_addr_b;
    ram_data_b = fir_mem_data_in_b;
    ram_we_b   = 1'b0;
    case (state)
      ST_LOAD: begin
        ram_addr_b = ADDR_W'(IN_BASE) + idx;
        ram_data_b = in_data;
        ram_we_b   = in_fire;
      end
      ST_RUN:   ram_we_b   = fir_mem_we_b;
      ST_DRAIN: ram_addr_a = ADDR_W'(OUT_BASE) + idx;
      default:  ram_we_b   = 1'b0;
    endcase
    if (rst) ram_we_b = 1'b0;
  end

  assign fir_mem_data_out_a = ram_data_a;

  sample_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk    (clk),
    .addr_a (ram_addr_a),
    .data_a (ram_data_a),
    .addr_b (ram_addr_b),
    .data_b (ram_data_b),
    .we_b   (ram_we_b)
  );

  // Job FSM with its length/index/timer registers and the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      idx       <= '0;
      timer     <= '0;
      done_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      done_q <= fir_done;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && !cmd_bad) begin
            len   <= cmd_len;
            idx   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            idx <= idx + ONE;
            if (idx == len - ONE) state <= ST_KICK;
          end
        end
        ST_KICK: begin
          timer <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          timer <= timer + TW'(1);
          if (rise) begin
            idx   <= '0;
            state <= ST_DRAIN;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= ST_IDLE;
          end else if (drain_load) begin
            if (idx < len) begin
              out_valid <= 1'b1;
              out_data  <= ram_data_a;
              out_last  <= (idx == len - ONE);
              idx       <= idx + ONE;
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Bench for fir_job_sequencer: a behavioural FIR on the far side of the
// start/done handshake, a result scoreboard and directed plus random jobs.
module tb_fir_job_sequencer;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int OUT_BASE = 512;
  localparam int TIMEOUT  = 4096;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err;
  logic              fir_start;
  logic [ADDR_W-1:0] fir_input_addr;
  logic [ADDR_W-1:0] fir_output_addr;
  logic [ADDR_W-1:0] fir_sample_count;
  logic              fir_done;
  logic [ADDR_W-1:0] fir_mem_addr_a;
  logic [DATA_W-1:0] fir_mem_data_out_a;
  logic [ADDR_W-1:0] fir_mem_addr_b;
  logic [DATA_W-1:0] fir_mem_data_in_b;
  logic              fir_mem_we_b;

  logic [ADDR_W-1:0] fir_a;
  logic [ADDR_W-1:0] peek_addr;
  logic              peek_on;
  assign fir_mem_addr_a = peek_on ? peek_addr : fir_a;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int err_cnt = 0;
  int cur_len = 0;
  int fir_delay = 20;
  bit fir_no_done = 0;
  bit job_done_seen = 0;
  int ready_mode = 0;
  int pat_k = 0;
  logic [3:0] pat_bits = 4'b1001;  // out_ready sequence 1,0,0,1

  logic [7:0] job_data [0:511];
  logic [8:0] exp_q [$];           // {last, data}

  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  fir_job_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_len            (cmd_len),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .err                (err),
    .fir_start          (fir_start),
    .fir_input_addr     (fir_input_addr),
    .fir_output_addr    (fir_output_addr),
    .fir_sample_count   (fir_sample_count),
    .fir_done           (fir_done),
    .fir_mem_addr_a     (fir_mem_addr_a),
    .fir_mem_data_out_a (fir_mem_data_out_a),
    .fir_mem_addr_b     (fir_mem_addr_b),
    .fir_mem_data_in_b  (fir_mem_data_in_b),
    .fir_mem_we_b       (fir_mem_we_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The filter the behavioural FIR applies: y[i] = 3*x[i] + i (mod 256).
  function automatic logic [7:0] fir_fn(input logic [7:0] x, input int i);
    logic [31:0] t;
    t = 32'(x) * 32'd3 + 32'(i);
    return t[7:0];
  endfunction

  // ---------------- behavioural FIR ----------------
  // On start: drop done one cycle later, read each input through port A,
  // write the filtered value through port B, then raise done fir_delay
  // cycles after start (never, in no-done mode).
  initial begin
    fir_done = 1'b0;
    fir_mem_we_b = 1'b0;
    fir_a = '0;
    fir_mem_addr_b = '0;
    fir_mem_data_in_b = '0;
    forever begin
      @(negedge clk);
      if (fir_start) begin
        int n;
        start_cnt++;
        start_cyc = cyc;
        job_done_seen = 1'b0;
        chk("fir_sample_count", 32'(fir_sample_count), 32'(cur_len));
        n = cur_len;
        @(negedge clk);
        fir_done = 1'b0;
        for (int i = 0; i < n; i++) begin
          fir_a = ADDR_W'(i);
          #1;
          fir_mem_addr_b = ADDR_W'(OUT_BASE + i);
          fir_mem_data_in_b = fir_fn(fir_mem_data_out_a, i);
          fir_mem_we_b = 1'b1;
          @(negedge clk);
        end
        fir_mem_we_b = 1'b0;
        if (!fir_no_done) begin
          repeat (fir_delay - 1 - n) @(negedge clk);
          fir_done = 1'b1;
          job_done_seen = 1'b1;
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = pat_bits[pat_k % 4];
        pat_k++;
      end
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (err) err_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (!job_done_seen) chk("valid_before_done", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    while (!cmd_ready && g < 6000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len = ADDR_W'(len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Feed n samples with random gaps; in noisy mode the gaps carry an
  // illegal command that must be ignored outside IDLE.
  task automatic load_samples(input int n, input bit noise);
    int g;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        cmd_valid = noise;
        cmd_len = '0;
        @(posedge clk);
        #1;
      end
      cmd_valid = 1'b0;
      in_valid = 1'b1;
      in_data = job_data[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (g >= 50) chk("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input int dly, input bit noise);
    int s0, e0, g;
    wait_idle();
    s0 = start_cnt;
    e0 = err_cnt;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fir_fn(job_data[i], i)});
    cur_len = len;
    fir_delay = dly;
    fir_no_done = 1'b0;
    pat_k = 0;
    send_cmd(len);
    load_samples(len, noise);
    g = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && g < 8000) begin
      @(negedge clk);
      g++;
    end
    chk("job_drained", 32'(exp_q.size()), 32'd0);
    chk("job_start_pulses", 32'(start_cnt - s0), 32'd1);
    chk("job_err_pulses", 32'(err_cnt - e0), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, e0, g, len;
    logic [7:0] in_lit [0:4];
    logic [7:0] out_lit [0:4];
    in_lit  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    out_lit = '{8'd30, 8'd61, 8'd92, 8'd123, 8'd154};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    peek_on = 1'b0;
    peek_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fir_start", 32'(fir_start), 32'd0);
    chk("rst_sample_count", 32'(fir_sample_count), 32'd0);
    chk("fir_input_addr", 32'(fir_input_addr), 32'd0);
    chk("fir_output_addr", 32'(fir_output_addr), 32'd512);

    // Job of 5 known samples, done 20 cycles after start.
    for (int i = 0; i < 5; i++) job_data[i] = in_lit[i];
    ready_mode = 0;
    run_job(5, 20, 1'b0);
    @(negedge clk);
    peek_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      peek_addr = ADDR_W'(i);
      #1;
      chk("ram_input", 32'(fir_mem_data_out_a), 32'(in_lit[i]));
      peek_addr = ADDR_W'(OUT_BASE + i);
      #1;
      chk("ram_output", 32'(fir_mem_data_out_a), 32'(out_lit[i]));
    end
    peek_on = 1'b0;

    // Rejected commands: zero length, above MAX_LEN, and one past MAX_LEN.
    wait_idle();
    s0 = start_cnt;
    e0 = err_cnt;
    cmd_valid = 1'b1;
    cmd_len = ADDR_W'(0);
    @(negedge clk);
    chk("err_len0", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    cmd_len = ADDR_W'(600);
    @(negedge clk);
    chk("err_len600", 32'(err), 32'd1);
    chk("busy_after_bad", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    cmd_len = ADDR_W'(513);
    @(negedge clk);
    chk("err_len513", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_err_low", 32'(err), 32'd0);
    chk("bad_err_count", 32'(err_cnt - e0), 32'd3);
    chk("bad_no_start", 32'(start_cnt - s0), 32'd0);

    // done still high from the previous job; it drops after start and
    // rises 30 cycles after start.
    for (int i = 0; i < 5; i++) job_data[i] = 8'($urandom_range(0, 255));
    run_job(5, 30, 1'b1);

    // Drain with out_ready cycling 1,0,0,1.
    for (int i = 0; i < 4; i++) job_data[i] = 8'($urandom_range(0, 255));
    ready_mode = 2;
    run_job(4, 20, 1'b0);
    ready_mode = 0;

    // Timeout: done never rises.
    wait_idle();
    s0 = start_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) job_data[i] = 8'($urandom_range(0, 255));
    cur_len = 3;
    fir_no_done = 1'b1;
    send_cmd(3);
    load_samples(3, 1'b0);
    g = 0;
    while (!err && g < TIMEOUT + 200) begin
      @(negedge clk);
      g++;
    end
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_cycles", 32'(cyc - start_cyc), 32'(TIMEOUT));
    @(negedge clk);
    chk("timeout_idle", 32'(cmd_ready), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_err_count", 32'(err_cnt - e0), 32'd1);
    chk("timeout_start_count", 32'(start_cnt - s0), 32'd1);
    fir_no_done = 1'b0;

    // Reset after 2 of 5 samples, then a fresh 3-sample job.
    wait_idle();
    s0 = start_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) job_data[i] = 8'($urandom_range(0, 255));
    cur_len = 5;
    send_cmd(5);
    load_samples(2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_no_start", 32'(start_cnt - s0), 32'd0);
    for (int i = 0; i < 3; i++) job_data[i] = 8'($urandom_range(0, 255));
    run_job(3, 20, 1'b0);

    // Random jobs including the length boundaries 1 and MAX_LEN.
    ready_mode = 1;
    for (int j = 0; j < 8; j++) begin
      if (j == 0) len = 1;
      else if (j == 1) len = 512;
      else len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) job_data[i] = 8'($urandom_range(0, 255));
      run_job(len, len + 3 + $urandom_range(0, 10), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #5000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
